// File: rtl/jtag_master.sv
// jtag_master: JTAG host engine turning IR-scan, DR-scan and TAP-reset commands into TCK/TMS/TDI sequences
// Ports: tck/trstn - source clock and asynchronous active-low reset
//        cmd_valid/cmd_ready/cmd_type/cmd_len/cmd_data - command channel (TDI bits LSB first)
//        rsp_valid/rsp_ready/rsp_data - captured TDO bits, held until consumed
//        jtag_tck/jtag_tms/jtag_tdi/jtag_tdo - pins to the target TAP
// Option: define JTAG_MASTER_IDLE_EN to append IDLE_CYCLES Run-Test/Idle cycles after every scan.
module jtag_master #(
    parameter int DATA_WIDTH  = 64,
    parameter int LEN_WIDTH   = $clog2(DATA_WIDTH + 1),
    parameter int TCK_DIV     = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                  tck,
    input  logic                  trstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  jtag_tck,
    output logic                  jtag_tms,
    output logic                  jtag_tdi,
    input  logic                  jtag_tdo
);
    localparam int CW = $clog2(DATA_WIDTH + IDLE_CYCLES + 8);
    localparam int DW = $clog2(TCK_DIV + 1);
    typedef enum logic [2:0] {
        INIT, IDLE, PRE, SHIFT, POST,
`ifdef JTAG_MASTER_IDLE_EN
        IDLE_WAIT,
`endif
        RSP
    } state_t;
    state_t                state, ns;
    logic [CW-1:0]         cnt, nc, cnt_nx, lim;
    logic [DW-1:0]         div;
    logic [LEN_WIDTH-1:0]  len, n_len, eff_len;
    logic [DATA_WIDTH-1:0] data;
    logic                  ir, n_ir, rst_cmd;
    logic                  fire, busy, tick, fall, n_tms, n_tdi;
    // Every JTAG bit is one (state, cnt) step; a step advances on the falling TCK edge,
    // where the TMS/TDI of the following step are launched.
    always_comb begin
        fire    = cmd_valid && cmd_ready;
        busy    = state != IDLE && state != RSP;
        tick    = div == DW'(TCK_DIV - 1);
        fall    = busy && tick && jtag_tck;
        eff_len = cmd_len > LEN_WIDTH'(DATA_WIDTH) ? LEN_WIDTH'(DATA_WIDTH) : cmd_len;
        cnt_nx  = cnt + CW'(1);
        lim     = state == INIT  ? CW'(6) :
                  state == PRE   ? (ir ? CW'(4) : CW'(3)) :
                  state == SHIFT ? CW'(len) :
`ifdef JTAG_MASTER_IDLE_EN
                  state == IDLE_WAIT ? CW'(IDLE_CYCLES) :
`endif
                  CW'(2);
        n_ir    = fire ? cmd_type == 2'b00 : ir;
        n_len   = fire ? eff_len : len;
        ns      = state;
        nc      = cnt;
        if (fire) begin
            ns = cmd_type == 2'b10 ? INIT : (!cmd_type[1] && eff_len != '0) ? PRE : RSP;
            nc = '0;
        end else if (state == RSP && rsp_ready) begin
            ns = IDLE;
        end else if (fall && cnt_nx != lim) begin
            nc = cnt_nx;
        end else if (fall) begin
            nc = '0;
            ns = state == INIT  ? (rst_cmd ? RSP : IDLE) :
                 state == PRE   ? SHIFT :
                 state == SHIFT ? POST :
`ifdef JTAG_MASTER_IDLE_EN
                 state == POST  ? IDLE_WAIT :
`endif
                 RSP;
        end
        n_tms = ns == INIT  ? nc < CW'(5) :
                ns == PRE   ? (n_ir ? nc < CW'(2) : nc == '0) :
                ns == SHIFT ? nc == CW'(n_len) - CW'(1) :
                ns == POST && nc == '0;
        n_tdi = ns == SHIFT && |(data & (DATA_WIDTH'(1) << nc));
    end
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state     <= INIT;
            cnt       <= '0;
            div       <= '0;
            len       <= '0;
            data      <= '0;
            ir        <= 1'b0;
            rst_cmd   <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
        end else begin
            state     <= ns;
            cnt       <= nc;
            div       <= (busy && !tick) ? div + DW'(1) : '0;
            jtag_tck  <= (busy && tick) ? !jtag_tck : jtag_tck;
            cmd_ready <= ns == IDLE;
            rsp_valid <= ns == RSP;
            if (fire || fall) begin
                jtag_tms <= n_tms;
                jtag_tdi <= n_tdi;
            end
            if (fire) begin
                len      <= eff_len;
                data     <= cmd_data;
                ir       <= cmd_type == 2'b00;
                rst_cmd  <= cmd_type == 2'b10;
                rsp_data <= '0;
            end
            // TDO is sampled in the cycle that raises TCK, i.e. the value the target launched on the previous fall
            if (busy && tick && !jtag_tck && state == SHIFT)
                rsp_data <= rsp_data | (DATA_WIDTH'(jtag_tdo) << cnt);
        end
    end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed bench for jtag_master with a behavioural 4-bit-IR TAP target
module tb_jtag_master;
    localparam logic [3:0] TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                           UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
    localparam logic [31:0] IDCODE = 32'hBADC0FFE;
    logic        tck = 0, trstn = 1, cmd_valid = 0, rsp_ready = 0, jtag_tdo = 0;
    logic [1:0]  cmd_type = 0;
    logic [6:0]  cmd_len = 0;
    logic [63:0] cmd_data = 0;
    logic        cmd_ready, rsp_valid, jtag_tck, jtag_tms, jtag_tdi;
    logic [63:0] rsp_data;
    int          n_chk = 0, n_pass = 0, n_edge = 0;
    logic [127:0] tms_log = '0, tdi_log = '0;
    logic [3:0]  st = TLR, tap_ir = 4'h1, ir_sr = 4'h0;
    logic [31:0] dr = 0;
    logic        bp = 0;

    always #5 tck = ~tck;

    jtag_master dut (
        .tck(tck), .trstn(trstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
    );

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:   return m ? TLR : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge jtag_tck) begin
        if (n_edge < 128) begin
            tms_log[n_edge] = jtag_tms;
            tdi_log[n_edge] = jtag_tdi;
        end
        n_edge++;
        case (st)
            TLR:   tap_ir = 4'h1;
            CAPDR: begin dr = IDCODE; bp = 0; end
            SHDR:  if (tap_ir == 4'h1) dr = {jtag_tdi, dr[31:1]}; else bp = jtag_tdi;
            CAPIR: ir_sr = 4'b0001;
            SHIR:  ir_sr = {jtag_tdi, ir_sr[3:1]};
            UPIR:  tap_ir = ir_sr;
            default: ;
        endcase
        st = tap_next(st, jtag_tms);
    end

    always @(negedge jtag_tck)
        jtag_tdo = st == SHDR ? (tap_ir == 4'h1 ? dr[0] : bp) : st == SHIR ? ir_sr[0] : 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic run(input logic [1:0] t, input int l, input logic [63:0] d, input int hold,
                       output logic [63:0] r, output int lat);
        int k, e;
        logic bad_rsp, bad_idle;
        k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge tck); k++; end
        check("cmd_ready", cmd_ready, 1);
        cmd_type = t; cmd_len = 7'(l); cmd_data = d; cmd_valid = 1;
        n_edge = 0; tms_log = '0; tdi_log = '0;
        @(negedge tck);
        cmd_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin @(negedge tck); lat++; end
        check("rsp_valid", rsp_valid, 1);
        r = rsp_data;
        if (hold > 0) begin
            e = n_edge; bad_rsp = 0; bad_idle = 0;
            repeat (hold) begin
                @(negedge tck);
                bad_rsp  |= !rsp_valid || rsp_data !== r;
                bad_idle |= cmd_ready || jtag_tck;
            end
            check("hold_rsp", bad_rsp, 0);
            check("hold_idle", bad_idle, 0);
            check("hold_edges", n_edge, e);
        end
        rsp_ready = 1;
        @(negedge tck);
        rsp_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] r;
        int lat, cyc, k;
        #2 trstn = 0;
        @(negedge tck); @(negedge tck);
        check("rst_tms", jtag_tms, 1);
        check("rst_tck", jtag_tck, 0);
        check("rst_tdi", jtag_tdi, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        n_edge = 0; tms_log = '0;
        trstn = 1;
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin @(negedge tck); cyc++; end
        check("init_cycles_ok", cyc >= 22 && cyc <= 26, 1);
        check("init_tms", tms_log[5:0], 6'b011111);
        check("init_edges", n_edge, 6);
        // IDCODE scan after reset
        run(2'b01, 32, 64'h0, 0, r, lat);
        check("idcode", r, 64'h00000000BADC0FFE);
        check("dr_tms", tms_log[63:0], 64'h0000000C00000001);
        check("dr_edges", n_edge, 37);
        // over-long scan clamps to 64 bits; TDI reappears after the 32-bit IDCODE register
        run(2'b01, 100, 64'h0123456789ABCDEF, 0, r, lat);
        check("clamp_data", r, 64'h89ABCDEFBADC0FFE);
        check("clamp_edges", n_edge, 69);
        check("clamp_tms_hi", tms_log[127:64], 64'hC);
        // IR scan loading 4'hA
        run(2'b00, 4, 64'hA, 0, r, lat);
        check("ir_rsp", r, 64'h1);
        check("ir_tms", tms_log[9:0], 10'h183);
        check("ir_tdi", tdi_log[7:4], 4'hA);
        check("ir_tdi_quiet", {tdi_log[9:8], tdi_log[3:0]}, 0);
        check("ir_edges", n_edge, 10);
        check("tap_ir", tap_ir, 4'hA);
        // bypass DR scan with response held back
        run(2'b01, 8, 64'hA5, 20, r, lat);
        check("bypass", r, 64'h4A);
        // TAP reset command
        run(2'b10, 5, 64'hFF, 0, r, lat);
        check("tapr_data", r, 0);
        check("tapr_edges", n_edge, 6);
        check("tapr_tms", tms_log[5:0], 6'b011111);
        check("tapr_ir", tap_ir, 4'h1);
        // reserved type and zero length: immediate empty response
        run(2'b11, 8, 64'hFF, 0, r, lat);
        check("resv_data", r, 0);
        check("resv_edges", n_edge, 0);
        check("resv_lat_ok", lat <= 2, 1);
        run(2'b01, 0, 64'hFF, 0, r, lat);
        check("len0_data", r, 0);
        check("len0_edges", n_edge, 0);
        check("len0_lat_ok", lat <= 2, 1);
        // reset during shift bit 10 of a DR scan, with IR left at bypass
        run(2'b00, 4, 64'hA, 0, r, lat);
        check("tap_ir2", tap_ir, 4'hA);
        k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge tck); k++; end
        cmd_type = 2'b01; cmd_len = 7'd32; cmd_data = 64'hFFFF; cmd_valid = 1;
        n_edge = 0;
        @(negedge tck);
        cmd_valid = 0;
        k = 0;
        while (n_edge < 14 && k < 500) begin @(negedge tck); k++; end
        check("abort_reached", n_edge, 14);
        trstn = 0;
        #1;
        check("abort_tms", jtag_tms, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_data", rsp_data, 0);
        check("abort_tck", jtag_tck, 0);
        @(negedge tck); @(negedge tck);
        trstn = 1;
        run(2'b01, 32, 64'h0, 0, r, lat);
        check("post_rst_idcode", r, 64'h00000000BADC0FFE);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtag_master.md
# jtag_master

JTAG host-side engine that drives a TAP target (TCK/TMS/TDI) and samples its TDO, turning single IR-scan, DR-scan and TAP-reset commands into correct TMS/TDI bit sequences. It sits on the debug/test side of the design, in front of the on-chip TAP and its data registers (IDCODE, AXI address/data registers). A bench or host controller issues commands over a valid/ready interface and gets back the captured TDO bits.

## Interface
- `DATA_WIDTH`, 64: maximum scan length in bits; width of `cmd_data` and `rsp_data`.
- `LEN_WIDTH`, `$clog2(DATA_WIDTH+1)`: width of `cmd_len`.
- `TCK_DIV`, 2: source-clock cycles per half period of `jtag_tck`; minimum 1.
- `IDLE_CYCLES`, 8: Run-Test/Idle JTAG cycles appended after every scan. Only used when `JTAG_MASTER_IDLE_EN` is defined.

- `tck`  in  1  source clock; all logic on its rising edge.
- `trstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_type`  in  2  command type: 00 IR scan, 01 DR scan, 10 TAP reset, 11 reserved.
- `cmd_len`  in  LEN_WIDTH  number of bits to shift.
- `cmd_data`  in  DATA_WIDTH  TDI bits, LSB shifted first.
- `rsp_valid`  out  1  response valid; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DATA_WIDTH  captured TDO bits, bit i = i-th shifted bit.
- `jtag_tck`  out  1  generated TCK.
- `jtag_tms`  out  1  TMS to target.
- `jtag_tdi`  out  1  TDI to target.
- `jtag_tdo`  in  1  TDO from target.

## Operation
- States: INIT, IDLE, PRE (TMS header), SHIFT, POST (exit/update/RTI), IDLE_WAIT (only with macro), RSP.
- INIT, entered on reset: 5 JTAG cycles with TMS=1 (Test-Logic-Reset), then 1 with TMS=0 (Run-Test/Idle). Then IDLE.
- IDLE: `cmd_ready`=1 only when in IDLE and no response is pending.
- IR scan TMS sequence: 1,1,0,0, then L shift bits (TMS=0 for the first L-1, TMS=1 on the last), then 1,0. Total L+6 JTAG cycles.
- DR scan TMS sequence: 1,0,0, then L shift bits, then 1,0. Total L+5 JTAG cycles.
- TAP reset command: same sequence as INIT (6 cycles); `rsp_data`=0.
- Reserved type 11: no JTAG activity; immediate response with `rsp_data`=0.
- `jtag_tdi` carries `cmd_data[i]` during shift bit i; it is 0 outside SHIFT.
- Length: `cmd_len`=0 produces no JTAG activity and an immediate response with data 0. `cmd_len`>`DATA_WIDTH` is clamped to `DATA_WIDTH`.
- `rsp_data[i]` is the TDO sampled on shift bit i. Bits ≥ L are 0.
- The master always ends a command in Run-Test/Idle.
- RSP: `rsp_valid`=1 and `rsp_data` stable until `rsp_ready`; the next cycle returns to IDLE.

## Timing
- Reset values: `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- `jtag_tck` toggles every `TCK_DIV` `tck` cycles, so one JTAG bit takes 2·`TCK_DIV` cycles.
- `jtag_tms` and `jtag_tdi` change only in the `tck` cycle where `jtag_tck` falls.
- `jtag_tdo` is sampled in the `tck` cycle where `jtag_tck` rises.
- The first JTAG cycle of a command starts within 1 `tck` of acceptance.
- `rsp_valid` rises 1 `tck` after the last POST falling edge.
- `trstn` asserted mid-command: outputs take reset values immediately and any partial response is discarded. After release, INIT reruns.
- `jtag_tck` is held at 0 while idle.

## Configuration
- `JTAG_MASTER_IDLE_EN` defined: after each IR/DR scan, the master holds TMS=0 for `IDLE_CYCLES` extra JTAG cycles (IDLE_WAIT) before the response. This gives the target time to finish AXI transactions.
- Undefined: IDLE_WAIT is removed and the response follows POST directly.

## Test plan
- Release `trstn`, `TCK_DIV`=2 → TMS is 1 on the first 5 `jtag_tck` rising edges and 0 on the 6th; `cmd_ready` rises 1 `tck` later (~24 cycles).
- DR scan, L=32, `cmd_data`=0, TAP model in IDCODE after reset → TMS 1,0,0,0×31,1,1,0; `rsp_data`=0x00000000BADC0FFE.
- IR scan, L=4, `cmd_data`=4'hA, TAP model → TDI bits 0,1,0,1 on shift edges; TMS 1,1,0,0,0,0,0,1,1,0; TAP IR updates to 4'hA.
- Hold `rsp_ready`=0 for 20 cycles after a scan → `rsp_valid` stays 1, `rsp_data` stable, `cmd_ready`=0, `jtag_tck` idle at 0.
- `cmd_len`=0 → response in ≤2 cycles with data 0 and no `jtag_tck` edge. `cmd_len`=100 with `DATA_WIDTH`=64 → exactly 64 shift edges.
- Assert `trstn` at shift bit 10 of a DR scan → `jtag_tms`=1 and `rsp_valid`=0 immediately; INIT reruns after release and the next IDCODE scan returns 0xBADC0FFE.
